// File: rtl/wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

  // Upper bound on the requester index width carried in the lock-in record.
  localparam int unsigned MaxIdxW = 16;

  // A burst counter must reach weight+1, so it needs one bit more than a weight.
  function automatic int unsigned cnt_width(input int unsigned weight_w);
    return weight_w + 1;
  endfunction

  // Lock-in record: a stalled decision and the requester it belongs to.
  typedef struct packed {
    logic               lock;
    logic [MaxIdxW-1:0] idx;
  } lock_t;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
module lzc #(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Width)
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    cnt_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CntW'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with lookahead, valid/ready handshake and lock-in.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0][WEIGHT_W-1:0]  weight_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [IDX_W-1:0]                  idx_o
);

  localparam int unsigned CntW = cnt_width(WEIGHT_W);

  typedef logic [WEIGHT_W-1:0] weight_t;
  typedef logic [CntW-1:0]     cnt_t;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  cnt_t             cnt_q, cnt_d;
  lock_t            lock_q, lock_d;

  logic [IDX_W-1:0]   lock_idx;
  logic               unused_lock_idx;
  weight_t            weight_sel;
  logic               locked;
  logic               burst_cont;
  logic [NUM_REQ-1:0] req_upper;
  logic [IDX_W-1:0]   idx_upper, idx_all, look_idx, sel_idx;
  logic               empty_upper, empty_all;

  assign lock_idx        = lock_q.idx[IDX_W-1:0];
  assign unused_lock_idx = ^lock_q.idx[MaxIdxW-1:IDX_W];
  assign weight_sel      = weight_i[ptr_q];

  // Requests strictly above the current owner; the owner itself ranks last.
  always_comb begin
    req_upper = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_upper[i] = req_i[i] & (IDX_W'(i) > ptr_q);
    end
  end

  lzc #(
    .Width (NUM_REQ)
  ) u_lzc_upper (
    .in_i    (req_upper),
    .cnt_o   (idx_upper),
    .empty_o (empty_upper)
  );

  lzc #(
    .Width (NUM_REQ)
  ) u_lzc_all (
    .in_i    (req_i),
    .cnt_o   (idx_all),
    .empty_o (empty_all)
  );

  // Selection priority: lock-in, then burst continuation, then wrap-around lookahead.
  always_comb begin
    locked     = lock_q.lock & req_i[lock_idx];
    burst_cont = (cnt_q != '0) && (cnt_q <= cnt_t'(weight_sel)) && req_i[ptr_q];
    look_idx   = empty_upper ? idx_all : idx_upper;
    if (locked) begin
      sel_idx = lock_idx;
    end else if (burst_cont) begin
      sel_idx = ptr_q;
    end else begin
      sel_idx = look_idx;
    end
  end

  // Outputs depend on requests and state only; ready_i never reaches them.
  always_comb begin
    valid_o = ~empty_all;
    gnt_o   = '0;
    idx_o   = '0;
    if (valid_o) begin
      gnt_o[sel_idx] = 1'b1;
      idx_o          = sel_idx;
    end
  end

  // Next state: hold a stalled decision, advance burst or owner on a transfer.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lock_d.lock = valid_o & ~ready_i;
    lock_d.idx  = MaxIdxW'(sel_idx);
    if (valid_o && ready_i) begin
      if ((sel_idx == ptr_q) && burst_cont) begin
        cnt_d = cnt_q + cnt_t'(1);
      end else begin
        ptr_d = sel_idx;
        cnt_d = cnt_t'(1);
      end
    end
  end

  // State register; flush behaves exactly like reset and wins over a transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      ptr_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q  <= '0;
      lock_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_valid_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o == (|gnt_o));
  a_gnt_idx : assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> gnt_o[idx_o]);
  // A requester whose decision is stalled must keep requesting until accepted.
  a_lock_held : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    lock_q.lock |-> req_i[lock_idx]);
`endif

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter with lookahead, valid/ready handshake and mandatory decision lock-in. It is the parametrised successor to the plain round-robin arbiter. Each requester may hold the grant for a configurable burst of consecutive transfers before priority rotates to the next active requester. It sits in front of shared resources (memory ports, interconnect slaves) whose downstream side can stall.

## Interface
- `NUM_REQ`, default 8: number of requesters; must be ≥ 2.
- `WEIGHT_W`, default 4: width of each per-requester weight.
- `IDX_W`, default `$clog2(NUM_REQ)`: index width; not to be overridden.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. Synchronous, active-low: sampled on the rising edge of `clk_i`.
- `flush_i`  in  1: synchronous clear of all state. Same effect as reset.
- `req_i`  in  NUM_REQ: request vector.
- `weight_i`  in  NUM_REQ×WEIGHT_W: per-requester weight. A weight of w grants a burst of up to w+1 transfers. Quasi-static.
- `valid_o`  out  1: a decision is presented. Equals `|req_i`.
- `ready_i`  in  1: downstream accepts. A transfer happens on `valid_o & ready_i`.
- `gnt_o`  out  NUM_REQ: one-hot grant. Equals `'0` when `valid_o` is 0.
- `idx_o`  out  IDX_W: index of the granted requester. Equals 0 when `valid_o` is 0.

## Operation
State registers:
- `ptr_q` (IDX_W): current burst owner.
- `cnt_q` (WEIGHT_W+1): transfers completed in the current burst. 0 means no burst is active.
- `lock_q` (1) and `lock_idx_q` (IDX_W): lock-in state.
- Reset and flush values: `ptr_q`=NUM_REQ-1, `cnt_q`=0, `lock_q`=0, `lock_idx_q`=0.

Combinational selection, in priority order:
1. **Locked:** if `lock_q` and `req_i[lock_idx_q]`, select `lock_idx_q`.
2. **Burst continues:** if `cnt_q`≠0, `cnt_q` ≤ `weight_i[ptr_q]` and `req_i[ptr_q]`, select `ptr_q`.
3. **Lookahead:** otherwise select the first set bit of `req_i` strictly above `ptr_q`, wrapping around. `ptr_q` itself is the lowest priority.

Register updates:
- **Lock-in:**
  - `lock_d` = `valid_o & ~ready_i`.
  - `lock_idx_d` = the selected index.
  - A stalled decision is therefore held until it is accepted.
  - If the locked requester withdraws its request, the lock is void and normal selection applies. This is a protocol violation and is flagged by an assertion.
- **On a transfer with selected index s:**
  - If s = `ptr_q` and the burst-continue condition holds: `cnt_q` ← `cnt_q`+1.
  - Otherwise: `ptr_q` ← s and `cnt_q` ← 1.
- **No transfer:** `ptr_q` and `cnt_q` hold.
- **Weights:**
  - Compared live, with zero-extension to WEIGHT_W+1.
  - Lowering a weight mid-burst below `cnt_q` ends the burst at the next decision.
  - The counter never exceeds 2^WEIGHT_W, so it cannot overflow.
- **Flush or reset with a stalled transfer pending:** the lock is dropped. The next cycle arbitrates from requester 0.

## Timing
- `gnt_o`, `idx_o` and `valid_o` are combinational from `req_i` and state. There are no cycles of latency from request to grant.
- No combinational path from `ready_i` to `gnt_o` or `idx_o`. `ready_i` only affects registers.
- State changes take effect in the cycle after the transfer edge.
- With `flush_i` and a transfer in the same cycle, flush wins.
- With a single active requester, it receives back-to-back grants indefinitely. After each burst of w+1 it starts a new burst: `cnt_q` restarts at 1.

## Structure
- Package `wrr_arbiter_pkg` holds the reusable definitions:
  - `weight_t` (parametrised via the module's typedef).
  - The `cnt_t` width rule, WEIGHT_W+1.
  - The lock-in state struct (`lock`, `idx`).
- The wrap-around search reuses the existing `lzc`, as two instances:
  - One on the request bits above `ptr_q`.
  - One on all requests.
  - Fallback order: upper first, then all.
- No other sub-module.
- Assertions, excluded from synthesis:
  - `gnt_o` is one-hot or zero.
  - `valid_o` ⇔ `|gnt_o`.
  - `gnt_o[idx_o]` when `valid_o`.
  - A locked request is held until accepted.

## Test plan
- **Reset and first grant:** reset, then `req_i`=8'hFF, all weights 0, `ready_i`=1 → grants 0,1,2,…,7,0 on consecutive cycles.
- **Weighted bursts:** `weight_i[2]`=3, `weight_i[5]`=1, all others 0, `req_i`=8'h24 → grant sequence 2,2,2,2,5,5,2,2,2,2.
- **Lookahead and lock-in:**
  - `req_i`=8'h90 with `ready_i`=0 for 3 cycles → `idx_o` stays 4 and `valid_o`=1 throughout.
  - `ready_i`=1 → transfer on 4, next grant 7.
  - Raising `req_i[5]` during the stall does not change `idx_o`.
- **Early burst end:** `weight_i[1]`=7, `req_i[1]` drops after 2 transfers with `req_i[3]` active → the next grant is 3.
- **Weight lowered mid-burst:** `weight_i[1]` lowered from 7 to 1 after 3 transfers on 1 → the next decision leaves requester 1.
- **Flush:**
  - Flush asserted mid-burst and during a stall → state returns to reset values the next cycle.
  - With `req_i`=8'h0A, the next grant is 1.
  - With `req_i`=0 → `gnt_o`=0 and `idx_o`=0.
